// File: rtl/mic_clap_controller_if.sv
// PDM microphone pin bundle: clock and channel select from the
// controller (master), 1-bit data back from the microphone (slave).
interface mic_clap_controller_if;
  logic M_CLK;
  logic M_LRSEL;
  logic M_DATA;

  modport master (
    output M_CLK,
    output M_LRSEL,
    input  M_DATA
  );

  modport slave (
    input  M_CLK,
    input  M_LRSEL,
    output M_DATA
  );
endinterface

// File: rtl/mic_clap_controller.sv
// PDM mic sequencer: M_CLK generation, window decimation into
// |ones - half| activity, and warm-up/listen/hold-off clap detection.
// Ports: clk, reset_n (sync, active-low), enable_mike, mic (master
//   bundle: M_CLK, M_LRSEL, M_DATA), clap, activity, activity_valid,
//   state, LED.
// Option: define MIC_LEVEL_LED_EN to build the LED bar graph;
//   otherwise LED is tied to 0.
module mic_clap_controller #(
  parameter int CLK_DIV         = 20,
  parameter int WINDOW_LOG2     = 8,
  parameter int THRESHOLD       = 64,
  parameter int WARMUP_WINDOWS  = 100,
  parameter int HOLDOFF_WINDOWS = 2000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable_mike,
  mic_clap_controller_if.master  mic,
  output logic                   clap,
  output logic [WINDOW_LOG2-1:0] activity,
  output logic                   activity_valid,
  output logic [1:0]             state,
  output logic [15:0]            LED
);

  localparam int W = WINDOW_LOG2;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WARMUP  = 2'd1;
  localparam logic [1:0] LISTEN  = 2'd2;
  localparam logic [1:0] HOLDOFF = 2'd3;

  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [11:0] WU_LAST  = 12'(WARMUP_WINDOWS - 1);
  localparam logic [11:0] HO_LAST  = 12'(HOLDOFF_WINDOWS - 1);
  localparam logic [W-1:0] THR     = W'(THRESHOLD);
  localparam logic [W:0]  HALF     = {2'b01, {(W-1){1'b0}}};

  logic         m_clk;
  logic [7:0]   div_cnt;
  logic [W-1:0] samp_cnt;
  logic [W:0]   ones;
  logic [W:0]   total;
  logic [11:0]  win_cnt;
  logic [W-1:0] act_nxt;
  logic         div_last;
  logic         sample_stb;
  logic         win_close;
  logic         loud;

  assign mic.M_CLK   = m_clk;
  assign mic.M_LRSEL = 1'b1;

  assign div_last   = div_cnt == DIV_LAST;
  // Sample on the high->low M_CLK edge.
  assign sample_stb = (state != IDLE) && div_last && m_clk;
  assign win_close  = sample_stb && (samp_cnt == '1);

  // total spans 0..2^W, so |total - half| always fits in W bits.
  assign total   = ones + {{W{1'b0}}, mic.M_DATA};
  assign act_nxt = (total >= HALF) ? W'(total - HALF)
                                   : W'(HALF - total);
  assign loud    = act_nxt >= THR;

`ifdef MIC_LEVEL_LED_EN
  logic [W+4:0] lvl;
  logic [15:0]  led_nxt;

  // lvl = act >> (W-5), written so it also holds for W < 5.
  always_comb begin
    lvl     = {act_nxt, 5'b0} >> W;
    led_nxt = '0;
    for (int i = 0; i < 16; i++) begin
      led_nxt[i] = lvl > (W+5)'(i);
    end
  end
`else
  assign LED = 16'h0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      m_clk          <= 1'b0;
      div_cnt        <= '0;
      samp_cnt       <= '0;
      ones           <= '0;
      win_cnt        <= '0;
      clap           <= 1'b0;
      activity       <= '0;
      activity_valid <= 1'b0;
`ifdef MIC_LEVEL_LED_EN
      LED            <= '0;
`endif
    end else if (!enable_mike) begin
      // Any in-flight window close is dropped here.
      state          <= IDLE;
      m_clk          <= 1'b0;
      div_cnt        <= '0;
      samp_cnt       <= '0;
      ones           <= '0;
      win_cnt        <= '0;
      clap           <= 1'b0;
      activity_valid <= 1'b0;
`ifdef MIC_LEVEL_LED_EN
      LED            <= '0;
`endif
    end else if (state == IDLE) begin
      state          <= WARMUP;
      win_cnt        <= '0;
      clap           <= 1'b0;
      activity_valid <= 1'b0;
    end else begin
      clap           <= 1'b0;
      activity_valid <= 1'b0;

      if (div_last) begin
        div_cnt <= '0;
        m_clk   <= ~m_clk;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end

      if (win_close) begin
        samp_cnt       <= '0;
        ones           <= '0;
        activity       <= act_nxt;
        activity_valid <= 1'b1;
`ifdef MIC_LEVEL_LED_EN
        LED            <= led_nxt;
`endif
        unique case (1'b1)
          state == WARMUP: begin
            if (win_cnt == WU_LAST) begin
              state   <= LISTEN;
              win_cnt <= '0;
            end else begin
              win_cnt <= win_cnt + 12'd1;
            end
          end
          state == LISTEN: begin
            if (loud) begin
              clap    <= 1'b1;
              state   <= HOLDOFF;
              win_cnt <= '0;
            end
          end
          state == HOLDOFF: begin
            if (win_cnt == HO_LAST) begin
              state   <= LISTEN;
              win_cnt <= '0;
            end else begin
              win_cnt <= win_cnt + 12'd1;
            end
          end
          default: ;
        endcase
      end else if (sample_stb) begin
        samp_cnt <= samp_cnt + {{(W-1){1'b0}}, 1'b1};
        ones     <= ones + {{W{1'b0}}, mic.M_DATA};
      end
    end
  end

endmodule

// File: tb/tb_mic_clap_controller.sv
// Randomized bench for mic_clap_controller against a window-level
// model driven by the documented timing (small parameters).
module tb_mic_clap_controller;

  localparam int D    = 2;
  localparam int WL   = 4;
  localparam int THR  = 4;
  localparam int WU   = 3;
  localparam int HO   = 4;
  localparam int NS   = 1 << WL;
  localparam int HALF = NS / 2;
  localparam int SP   = 2 * D;
  localparam int WIN  = NS * SP;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable_mike = 1'b0;
  logic          clap;
  logic [WL-1:0] activity;
  logic          activity_valid;
  logic [1:0]    state;
  logic [15:0]   LED;

  mic_clap_controller_if mic ();

  mic_clap_controller #(
    .CLK_DIV        (D),
    .WINDOW_LOG2    (WL),
    .THRESHOLD      (THR),
    .WARMUP_WINDOWS (WU),
    .HOLDOFF_WINDOWS(HO)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable_mike   (enable_mike),
    .mic           (mic),
    .clap          (clap),
    .activity      (activity),
    .activity_valid(activity_valid),
    .state         (state),
    .LED           (LED)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int exp_act = 0;
  int exp_led = 0;
  int warm_left;
  int hold_left;
  int cur_k;
  bit win_bits[NS];
  int plan[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int led_of(input int a);
`ifdef MIC_LEVEL_LED_EN
    int n;
    n = (a * 32) >> WL;
    if (n > 16) n = 16;
    return (1 << n) - 1;
`else
    return 0 * a;
`endif
  endfunction

  // sp: -1 alternating 0/1, -2 random count, else exact ones count.
  task automatic new_window(input int sp);
    int k;
    int j;
    bit t;
    if (sp == -1) begin
      for (int i = 0; i < NS; i++) win_bits[i] = bit'(i % 2);
      cur_k = NS / 2;
    end else begin
      k = (sp < 0) ? int'($urandom_range(0, NS)) : sp;
      for (int i = 0; i < NS; i++) win_bits[i] = (i < k);
      for (int i = NS - 1; i > 0; i--) begin
        j = int'($urandom_range(0, i));
        t = win_bits[i];
        win_bits[i] = win_bits[j];
        win_bits[j] = t;
      end
      cur_k = k;
    end
  endtask

  function automatic int exp_state();
    if (warm_left > 0) return 1;
    if (hold_left > 0) return 3;
    return 2;
  endfunction

  // Called at a negedge with the DUT in IDLE. Runs ncyc cycles,
  // then drops enable (or asserts reset) during the last one.
  task automatic session(input int ncyc, input bit end_rst);
    int  a;
    int  sp;
    int  w;
    bit  ev;
    bit  ec;
    warm_left   = WU;
    hold_left   = 0;
    enable_mike = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      ev = 1'b0;
      ec = 1'b0;
      if (c > 0 && c % WIN == 0) begin
        ev = 1'b1;
        a = (cur_k >= HALF) ? cur_k - HALF : HALF - cur_k;
        exp_act = a;
        exp_led = led_of(a);
        if (warm_left > 0) begin
          warm_left--;
        end else if (hold_left > 0) begin
          hold_left--;
        end else if (a >= THR) begin
          ec = 1'b1;
          hold_left = HO;
        end
      end
      chk("m_clk", mic.M_CLK, (c / D) % 2);
      chk("lrsel", mic.M_LRSEL, 1);
      chk("state", state, exp_state());
      chk("act_valid", activity_valid, ev);
      chk("clap", clap, ec);
      chk("activity", activity, exp_act);
      chk("led", LED, exp_led);
      if (c % WIN == 0) begin
        w  = c / WIN;
        sp = (w < plan.size()) ? plan[w] : -2;
        new_window(sp);
      end
      mic.M_DATA = win_bits[(c / SP) % NS];
      if (c == ncyc - 1) begin
        if (end_rst) reset_n = 1'b0;
        else enable_mike = 1'b0;
      end
    end
    @(negedge clk);
    if (end_rst) exp_act = 0;
    exp_led = 0;
    chk("off_state", state, 0);
    chk("off_m_clk", mic.M_CLK, 0);
    chk("off_valid", activity_valid, 0);
    chk("off_clap", clap, 0);
    chk("off_activity", activity, exp_act);
    chk("off_led", LED, 0);
    reset_n = 1'b1;
  endtask

  initial begin
    mic.M_DATA = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_clk", mic.M_CLK, 0);
    chk("rst_lrsel", mic.M_LRSEL, 1);
    chk("rst_clap", clap, 0);
    chk("rst_activity", activity, 0);
    chk("rst_valid", activity_valid, 0);
    chk("rst_state", state, 0);
    chk("rst_led", LED, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      mic.M_DATA = 1'($urandom_range(0, 1));
      chk("idle_m_clk", mic.M_CLK, 0);
      chk("idle_lrsel", mic.M_LRSEL, 1);
      chk("idle_state", state, 0);
      chk("idle_valid", activity_valid, 0);
      chk("idle_clap", clap, 0);
    end

    plan = '{-1, -1, -1, -1};
    session(WIN * 4, 1'b0);

    plan = '{NS, NS, NS, NS, NS, NS, NS, NS, NS, NS, NS, NS};
    session(WIN * 12 + int'($urandom_range(5, 50)), 1'b0);

    plan = '{-2, -2, -2, HALF + THR - 1, HALF - THR + 1,
             HALF + THR, NS, NS, NS, NS, HALF - THR};
    session(WIN * 22 + int'($urandom_range(5, 50)), 1'b1);

    plan = '{};
    session(WIN * 20, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
